// File: rtl/regfile_pkg.sv
// Shared helpers for the regfile arbiter slice.
// Address-width derivation and packed-slice index helpers.
package regfile_pkg;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req, priority pointer
// moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    input  logic            advance
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] pool;
    int              win;

    // Requests at or above the pointer win first, else wrap around.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        hi    = req & mask;
        pool  = (|hi) ? hi : req;
        grant = '0;
        win   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                win      = i;
            end
        end
        ptr_nxt = (win == NREQ - 1) ? '0 : PW'(win + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && |grant) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one regfile read and one write port among NREQ requesters,
// with next-cycle read response and same-cycle write-to-read bypass.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter  int N          = 8,
    parameter  int WIDTH      = 32,
    parameter  int NREQ       = 4,
    localparam int ADDR_WIDTH = addr_w(N)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]      req_wdata,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       R_en,
    output logic [ADDR_WIDTH-1:0]      R_addr,
    input  logic [WIDTH-1:0]           R_data,
    output logic                       W_en,
    output logic [ADDR_WIDTH-1:0]      W_addr,
    output logic [WIDTH-1:0]           W_data
);

    localparam logic [ADDR_WIDTH:0] NV = (ADDR_WIDTH + 1)'(N);

    logic [ADDR_WIDTH-1:0] addr_v  [NREQ];
    logic [WIDTH-1:0]      wdata_v [NREQ];

    logic [NREQ-1:0]       rd_cand;
    logic [NREQ-1:0]       wr_cand;
    logic [NREQ-1:0]       rd_grant;
    logic [NREQ-1:0]       wr_grant;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  rd_go;
    logic                  wr_go;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  bypass;

    logic [NREQ-1:0]       rsp_q;
    logic                  byp_q;
    logic                  oob_q;
    logic [WIDTH-1:0]      byp_data_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign addr_v[g]  = req_addr[slice_lo(g, ADDR_WIDTH) +: ADDR_WIDTH];
        assign wdata_v[g] = req_wdata[slice_lo(g, WIDTH) +: WIDTH];
    end

    assign rd_cand = req_valid & ~req_we;
    assign wr_cand = req_valid & req_we;

    rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (rd_cand),
        .grant   (rd_grant),
        .advance (~reset)
    );

    rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wr_cand),
        .grant   (wr_grant),
        .advance (~reset)
    );

    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_grant[i]) begin
                rd_addr = addr_v[i];
            end
            if (wr_grant[i]) begin
                wr_addr = addr_v[i];
                wr_data = wdata_v[i];
            end
        end
    end

    assign rd_go = ~reset & (|rd_grant);
    assign wr_go = ~reset & (|wr_grant);
    assign rd_ok = {1'b0, rd_addr} < NV;
    assign wr_ok = {1'b0, wr_addr} < NV;

    assign req_ready = reset ? '0 : (rd_grant | wr_grant);

    assign R_en   = rd_go & rd_ok;
    assign R_addr = rd_go ? rd_addr : '0;
    assign W_en   = wr_go & wr_ok;
    assign W_addr = wr_go ? wr_addr : '0;
    assign W_data = wr_go ? wr_data : '0;

    // Regfile is read-before-write, so a colliding read needs the new data.
    assign bypass = R_en & W_en & (rd_addr == wr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q      <= '0;
            byp_q      <= 1'b0;
            oob_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rsp_q      <= rd_go ? rd_grant : '0;
            byp_q      <= bypass;
            oob_q      <= rd_go & ~rd_ok;
            byp_data_q <= bypass ? wr_data : '0;
        end
    end

    assign rsp_valid = reset ? '0 : rsp_q;

    always_comb begin
        rsp_data = '0;
        if (!reset && (|rsp_q) && !oob_q) begin
            rsp_data = byp_q ? byp_data_q : R_data;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter against a behavioural
// round-robin / memory model, with a simple read-before-write regfile.
module tb_regfile_arbiter;

    localparam int N     = 6;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int AW    = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  R_en;
    logic [AW-1:0]         R_addr;
    logic [WIDTH-1:0]      R_data;
    logic                  W_en;
    logic [AW-1:0]         W_addr;
    logic [WIDTH-1:0]      W_data;

    logic [AW-1:0]         a_v [NREQ];
    logic [WIDTH-1:0]      d_v [NREQ];

    logic [WIDTH-1:0]      rf [N];
    logic                  rf_clr;

    logic [WIDTH-1:0]      ref_mem [N];
    int                    ptr_r;
    int                    ptr_w;
    logic [NREQ-1:0]       pend;
    logic [WIDTH-1:0]      pend_data;
    logic [NREQ-1:0]       last_er;
    int                    waitc [NREQ];

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = a_v[i];
            req_wdata[i*WIDTH +: WIDTH] = d_v[i];
        end
    end

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < N; i++) rf[i] <= '0;
        end else if (W_en) begin
            rf[W_addr] <= W_data;
        end
        if (R_en) R_data <= rf[R_addr];
    end

    regfile_arbiter #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .R_en      (R_en),
        .R_addr    (R_addr),
        .R_data    (R_data),
        .W_en      (W_en),
        .W_addr    (W_addr),
        .W_data    (W_data)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [NREQ-1:0] cand);
        for (int k = 0; k < NREQ; k++) begin
            if (cand[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input bit we,
                           input int addr, input logic [WIDTH-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        a_v[i]       = AW'(addr);
        d_v[i]       = d;
    endtask

    task automatic idle();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, '0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic [NREQ-1:0]  vr;
        logic [NREQ-1:0]  vw;
        logic [NREQ-1:0]  er;
        logic [NREQ-1:0]  pend_n;
        logic [WIDTH-1:0] pdata_n;
        bit               ren;
        bit               wen;
        int               r;
        int               w;
        @(negedge clk);
        vr = req_valid & ~req_we;
        vw = req_valid & req_we;
        r  = reset ? -1 : pick(ptr_r, vr);
        w  = reset ? -1 : pick(ptr_w, vw);
        er = '0;
        if (r >= 0) er[r] = 1'b1;
        if (w >= 0) er[w] = 1'b1;
        ren = (r >= 0) && (int'(a_v[r]) < N);
        wen = (w >= 0) && (int'(a_v[w]) < N);
        check("req_ready", req_ready, er);
        check("R_en", R_en, ren);
        check("W_en", W_en, wen);
        if (r >= 0) check("R_addr", R_addr, a_v[r]);
        if (w >= 0) begin
            check("W_addr", W_addr, a_v[w]);
            check("W_data", W_data, d_v[w]);
        end
        if (reset) begin
            check("R_addr_rst", R_addr, 0);
            check("W_addr_rst", W_addr, 0);
            check("W_data_rst", W_data, 0);
        end
        check("rsp_valid", rsp_valid, reset ? '0 : pend);
        if (reset || pend == '0) check("rsp_data_idle", rsp_data, 0);
        else check("rsp_data", rsp_data, pend_data);
        for (int i = 0; i < NREQ; i++) begin
            if (reset || !req_valid[i]) begin
                waitc[i] = 0;
            end else if (er[i]) begin
                check("starve", waitc[i] < NREQ, 1);
                waitc[i] = 0;
            end else begin
                waitc[i]++;
            end
        end
        pend_n  = '0;
        pdata_n = '0;
        if (r >= 0) begin
            pend_n[r] = 1'b1;
            if (!ren) pdata_n = '0;
            else if (wen && a_v[w] == a_v[r]) pdata_n = d_v[w];
            else pdata_n = ref_mem[a_v[r]];
        end
        last_er = er;
        @(posedge clk);
        if (reset) begin
            ptr_r = 0;
            ptr_w = 0;
            pend  = '0;
        end else begin
            if (r >= 0) ptr_r = (r + 1) % NREQ;
            if (w >= 0) ptr_w = (w + 1) % NREQ;
            if (wen) ref_mem[a_v[w]] = d_v[w];
            pend      = pend_n;
            pend_data = pdata_n;
        end
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        ptr_r     = 0;
        ptr_w     = 0;
        pend      = '0;
        pend_data = '0;
        last_er   = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        req_valid = '0;
        req_we    = '0;
        idle();
        rf_clr = 1'b1;
        reset  = 1'b1;

        // Reset with every requester asking to read.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, '0);
        step();
        rf_clr = 1'b0;
        step();
        reset = 1'b0;

        // Continuous reads rotate 0,1,2,3,0,...
        repeat (9) step();
        idle();
        step();

        // Write then read back through the regfile.
        set_req(2, 1'b1, 1'b1, 5, 32'hDEADBEEF);
        step();
        idle();
        set_req(1, 1'b1, 1'b0, 5, '0);
        step();
        idle();
        step();

        // Same-cycle write and read to one address uses the bypass.
        set_req(0, 1'b1, 1'b1, 3, 32'h12345678);
        set_req(3, 1'b1, 1'b0, 3, '0);
        step();
        idle();
        step();

        // Out-of-range write and read are accepted but dropped.
        set_req(1, 1'b1, 1'b1, 7, 32'hA5A5A5A5);
        set_req(2, 1'b1, 1'b0, 6, '0);
        step();
        idle();
        set_req(0, 1'b1, 1'b0, 5, '0);
        step();
        idle();
        step();

        // Reset right after a read handshake swallows the response.
        set_req(2, 1'b1, 1'b0, 3, '0);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, '0);
        step();
        step();
        idle();
        step();

        // Random traffic, honouring the hold-while-waiting rule.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !last_er[i]) begin
                    if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
                end else begin
                    set_req(i, $urandom_range(3) != 0, 1'($urandom_range(1)),
                            int'($urandom_range(7)), $urandom);
                end
            end
            reset = ($urandom_range(60) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
